// File: rtl/div_24bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, fixed latency.
// A req/ack handshake starts one division; results and div_by_zero hold until the next completion.
module div_24bit_seq #(
  parameter int width = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             ack,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [width-1:0] dq, dvs;
  logic [width:0]   rem;
  logic             dbz;
  logic             accept, last;

  logic [2*width:0] pair_sh;
  logic [width:0]   rem_sh, sub, rem_nxt;
  logic [width-1:0] dq_sh, dq_nxt;
  logic             ge;

  // {remainder, dividend} shift as one register pair; the dropped MSB is always zero
  always_comb begin
    pair_sh = {rem, dq} << 1;
    rem_sh  = pair_sh[2*width:width];
    dq_sh   = pair_sh[width-1:0];
    ge      = (rem_sh >= {1'b0, dvs});
    sub     = rem_sh - {1'b0, dvs};
    rem_nxt = ge ? sub : rem_sh;
    dq_nxt  = dq_sh | width'(ge);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == CW'(1)) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      dbz         <= 1'b0;
      ack         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= last;
      if (accept) begin
        dq  <= a;
        dvs <= b;
        rem <= '0;
        cnt <= CW'(width);
        dbz <= (b == '0);
      end else if (state == RUN) begin
        dq  <= dq_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CW'(1);
        // Divide by zero needs no special case: every trial succeeds, giving all ones and rem = a
        if (last) begin
          quotient    <= dq_nxt;
          remainder   <= rem_nxt[width-1:0];
          div_by_zero <= dbz;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_24bit_seq.sv
// Scoreboard bench for div_24bit_seq: driver pushes model results, a negedge monitor pops on ack.
module tb_div_24bit_seq;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, ack, div_by_zero;
  logic [W-1:0] quotient, remainder;

  div_24bit_seq #(.width(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
    .busy(busy), .ack(ack), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0, failures = 0;
  logic [W-1:0] last_q = '0, last_r = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
    exp_t e;
    if (y == '0) begin
      e.q = '1; e.r = x; e.z = 1'b1;
    end else begin
      e.q = x / y; e.r = x % y; e.z = 1'b0;
    end
    e.due = due;
    return e;
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation, at the expected cycle
  always @(negedge clk) begin
    if (rst && ack) begin
      chk("busy_low_with_ack", busy, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got quotient %0h expected no ack", quotient);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.z);
        chk("ack_cycle", cyc, mon_e.due);
        last_q = mon_e.q;
        last_r = mon_e.r;
      end
    end
  end

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; req = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(x, y, cyc + W));
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    chk("hold_q_on_accept", quotient, last_q);
    chk("hold_r_on_accept", remainder, last_r);
    req = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit got_ack;
    logic [W-1:0] x, y;

    #1 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    start(15, 4);              wait_done();
    start(1184944, 124);       wait_done();
    start(95562, 1000);        wait_done();
    start(24'hFFFFFF, 1);      wait_done();
    start(7, 9);               wait_done();
    start(1234, 0);            wait_done();
    start(24'hFFFFFF, 24'hFFFFFF); wait_done();

    // req while busy is ignored; req during the ack cycle is accepted back-to-back
    start(100, 7);
    repeat (4) @(negedge clk);
    a = 50; b = 5; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clk);
      #1;
      if (ack) got_ack = 1'b1;
    end
    if (!got_ack) begin
      checks++;
      failures++;
      $display("FAIL first_ack_timeout: got no ack expected ack");
    end else begin
      a = 50; b = 5; req = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(50, 5, cyc + W));
      @(negedge clk);
      chk("b2b_busy", busy, 1);
      req = 1'b0;
    end
    wait_done();

    // Asynchronous reset mid-operation
    start(1000, 3);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    sb.delete();
    last_q = '0;
    last_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    start(9, 3);               wait_done();

    // Randomized operands with a mix of divisor ranges and idle gaps
    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      case ($urandom_range(0, 3))
        0: y = W'($urandom);
        1: y = W'($urandom_range(0, 15));
        2: y = W'($urandom) >> $urandom_range(1, W - 1);
        default: y = (n % 8 == 0) ? '0 : W'($urandom_range(1, 4096));
      endcase
      start(x, y);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
